clk_div_gen: RTL

Multi-channel, run-time programmable clock divider for the ADC sample clock and CIS line clocks. Every channel runs from one clk_in domain and produces a registered divided clock plus single-cycle rise/fall strobes. Channels can be chained so that one channel divides the output of the previous one. Divisor changes, enable and disable all take effect only at period boundaries, so outputs never glitch.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_ch.sv | 93 +++++++++
 rtl/clk_div_gen.sv | 50 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Provides the channel state enum, the minimum divisor and the high-phase length function.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ch_state_e;

    localparam int unsigned MIN_DIV = 2;

    // High phase is ceil(d/2) so odd divisors spend the extra cycle high.
    function automatic int unsigned high_cycles(input int unsigned d);
        return d - (d >> 1);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: run/drain FSM, period counter, shadowed divisor and
// registered divided clock with rise/fall strobes.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 5
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             tick,
    input  logic             ch_en,
    input  logic             sync,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             div_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             cfg_pend
);

    ch_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] d_act;
    logic [CNT_W-1:0] d_pend;
    logic [CNT_W-1:0] d_eff;
    logic [CNT_W-1:0] d_last;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] d_pend_nxt;
    logic             active;
    logic             wrap;
    logic             apply;

    always_comb begin
        d_eff      = (d_act < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : d_act;
        d_last     = d_eff - CNT_W'(1);
        h_cnt      = CNT_W'(high_cycles(32'(d_eff)));
        active     = (state != IDLE);
        wrap       = active && tick && (cnt == d_last);
        // Divisor swaps only at a period boundary, a sync, or while stopped.
        apply      = !active || (active && sync) || wrap;
        d_pend_nxt = cfg_load ? cfg_div : d_pend;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            d_act    <= CNT_W'(DEF_DIV);
            d_pend   <= CNT_W'(DEF_DIV);
            div_out  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            cfg_pend <= 1'b0;
        end else begin
            d_pend   <= d_pend_nxt;
            cfg_pend <= (cfg_load || cfg_pend) && !apply;
            if (apply) begin
                d_act <= d_pend_nxt;
            end
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;

            unique case (state)
                IDLE: begin
                    cnt     <= '0;
                    div_out <= 1'b0;
                    if (ch_en) begin
                        state <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    state <= ch_en ? RUN : DRAIN;
                    if (sync) begin
                        cnt     <= '0;
                        div_out <= 1'b0;
                    end else if (tick) begin
                        div_out  <= (cnt < h_cnt);
                        rise_stb <= (cnt == '0);
                        fall_stb <= (cnt == h_cnt);
                        cnt      <= wrap ? '0 : cnt + CNT_W'(1);
                        if (wrap && (state == DRAIN) && !ch_en) begin
                            state   <= IDLE;
                            div_out <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: slices the divisor bus and
// selects each channel's tick source (free-running or upstream rise strobe).
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned       NUM_CH  = 2,
    parameter int unsigned       CNT_W   = 8,
    parameter int unsigned       DEF_DIV = 5,
    parameter logic [NUM_CH-1:0] CASCADE = 2'b10
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [NUM_CH*CNT_W-1:0] div_cfg,
    input  logic                    cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       div_out,
    output logic [NUM_CH-1:0]       rise_stb,
    output logic [NUM_CH-1:0]       fall_stb,
    output logic [NUM_CH-1:0]       cfg_pend
);

    logic [NUM_CH-1:0] tick;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        if (k == 0) begin : g_first
            assign tick[k] = 1'b1;
        end else begin : g_chain
            assign tick[k] = CASCADE[k] ? rise_stb[k-1] : 1'b1;
        end

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_in   (clk_in),
            .reset    (reset),
            .tick     (tick[k]),
            .ch_en    (ch_en[k]),
            .sync     (sync),
            .cfg_load (cfg_load),
            .cfg_div  (div_cfg[k*CNT_W +: CNT_W]),
            .div_out  (div_out[k]),
            .rise_stb (rise_stb[k]),
            .fall_stb (fall_stb[k]),
            .cfg_pend (cfg_pend[k])
        );
    end

endmodule
